// File: rtl/inst_line_fetcher_if.sv
// Downward-facing port bundle between inst_cache, the line fetcher and the burst memory.
// The fetcher uses the slave view; the environment (cache + memory) uses the master view.
interface inst_line_fetcher_if #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
);
    logic [31:0]       dfp_addr;
    logic              dfp_read;
    logic              dfp_write;
    logic [LINE_W-1:0] dfp_wdata;
    logic [LINE_W-1:0] dfp_rdata;
    logic              dfp_resp;

    logic [31:0]       bmem_addr;
    logic              bmem_read;
    logic              bmem_ready;
    logic [31:0]       bmem_raddr;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;

    modport slave (
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
        output dfp_rdata, dfp_resp,
        output bmem_addr, bmem_read,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );

    modport master (
        output dfp_addr, dfp_read, dfp_write, dfp_wdata,
        input  dfp_rdata, dfp_resp,
        input  bmem_addr, bmem_read,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );
endinterface

// File: rtl/inst_line_fetcher.sv
// Instruction-side line fetcher: assembles 256-bit lines from 64-bit memory bursts and
// keeps a one-line next-line prefetch buffer so sequential misses are answered in one cycle.
module inst_line_fetcher #(
    parameter bit PREFETCH_EN = 1'b1,
    parameter int BEATS       = 4,
    parameter int BEAT_W      = 64,
    parameter int LINE_W      = 256
) (
    input  logic                clk,
    input  logic                rst,
    inst_line_fetcher_if.slave  bus
);
    localparam int CNT_W      = $clog2(BEATS);
    localparam int OFS_W      = $clog2(LINE_W / 8);
    localparam int LINE_BYTES = LINE_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        D_REQ,
        D_FILL,
        RESP,
        P_REQ,
        P_FILL
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic [BEAT_W-1:0] r_beat [BEATS-1];
    logic [31:0]       r_req_addr;
    logic [31:0]       r_pf_addr;
    logic [31:0]       r_buf_tag;
    logic              r_buf_valid;
    logic [LINE_W-1:0] r_buf_data;
    logic [LINE_W-1:0] r_rdata;

    logic [31:0]       w_line_addr;
    logic [31:0]       w_burst_addr;
    logic              w_in_fill;
    logic              w_beat_take;
    logic              w_last_beat;
    logic              w_hit;
    logic [LINE_W-1:0] w_line;
    logic              w_bmem_read;
    logic [31:0]       w_bmem_addr;
    logic              w_unused;

    assign w_line_addr  = {bus.dfp_addr[31:OFS_W], {OFS_W{1'b0}}};
    assign w_burst_addr = (r_state == P_FILL) ? r_pf_addr : r_req_addr;
    assign w_in_fill    = (r_state == D_FILL) || (r_state == P_FILL);
    // Beats tagged with any other address belong to a burst abandoned by reset.
    assign w_beat_take  = w_in_fill && bus.bmem_rvalid && (bus.bmem_raddr == w_burst_addr);
    assign w_last_beat  = w_beat_take && (r_beat_cnt == CNT_W'(BEATS - 1));
    assign w_hit        = r_buf_valid && (r_buf_tag == w_line_addr);

    // The final beat is taken straight from the bus so the line is complete on that edge.
    genvar gi;
    generate
        for (gi = 0; gi < BEATS - 1; gi++) begin : g_beat
            always_ff @(posedge clk) begin
                if (w_beat_take && (r_beat_cnt == CNT_W'(gi))) begin
                    r_beat[gi] <= bus.bmem_rdata;
                end
            end
            assign w_line[gi*BEAT_W +: BEAT_W] = r_beat[gi];
        end
    endgenerate
    assign w_line[(BEATS-1)*BEAT_W +: BEAT_W] = bus.bmem_rdata;

    always_comb begin
        w_state_next = r_state;
        w_bmem_read  = 1'b0;
        w_bmem_addr  = '0;
        case (r_state)
            IDLE: begin
                if (bus.dfp_read) begin
                    w_state_next = w_hit ? RESP : D_REQ;
                end
            end
            D_REQ: begin
                w_bmem_read = 1'b1;
                w_bmem_addr = r_req_addr;
                if (bus.bmem_ready) begin
                    w_state_next = D_FILL;
                end
            end
            D_FILL: begin
                if (w_last_beat) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                w_state_next = PREFETCH_EN ? P_REQ : IDLE;
            end
            P_REQ: begin
                w_bmem_read = 1'b1;
                w_bmem_addr = r_pf_addr;
                if (bus.bmem_ready) begin
                    w_state_next = P_FILL;
                end
            end
            P_FILL: begin
                if (w_last_beat) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_beat_cnt  <= '0;
            r_buf_valid <= 1'b0;
            r_buf_tag   <= '0;
            r_req_addr  <= '0;
            r_pf_addr   <= '0;
            r_rdata     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_beat_take) begin
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
            if ((r_state == IDLE) && bus.dfp_read) begin
                r_req_addr <= w_line_addr;
                if (w_hit) begin
                    r_rdata <= r_buf_data;
                end
            end
            if ((r_state == D_FILL) && w_last_beat) begin
                r_rdata <= w_line;
            end
            if ((r_state == RESP) && PREFETCH_EN) begin
                r_pf_addr   <= r_req_addr + 32'(LINE_BYTES);
                r_buf_valid <= 1'b0;
            end
            if ((r_state == P_FILL) && w_last_beat) begin
                r_buf_tag   <= r_pf_addr;
                r_buf_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == P_FILL) && w_last_beat) begin
            r_buf_data <= w_line;
        end
    end

    assign bus.bmem_read = w_bmem_read;
    assign bus.bmem_addr = w_bmem_addr;
    assign bus.dfp_resp  = (r_state == RESP);
    assign bus.dfp_rdata = (r_state == RESP) ? r_rdata : '0;

    assign w_unused = ^{bus.dfp_wdata, bus.dfp_write, bus.dfp_addr[OFS_W-1:0]};

    // Line writes are not supported; a lone write would otherwise wait forever.
    a_no_lone_write: assert property (@(posedge clk) disable iff (rst)
        !(bus.dfp_write && !bus.dfp_read));
endmodule

// File: tb/tb_inst_line_fetcher.sv
// Randomized bench for inst_line_fetcher: plays cache and burst memory, and checks line data,
// response latency and the order of bursts against a line-level reference model.
module tb_inst_line_fetcher;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_line_fetcher_if bus_if ();

    inst_line_fetcher #(.PREFETCH_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model state
    logic [31:0] q_burst[$];
    logic [31:0] q_obs[$];
    int          head_beat     = 0;
    int          last_beat_cyc = -100;
    int          ready_mode    = 0;
    logic [31:0] salt;

    // Reference model state
    logic [31:0] q_exp[$];
    bit          pf_valid = 1'b0;
    logic [31:0] pf_line  = '0;
    logic [31:0] cur_la;
    bit          cur_hit;
    bit          cur_quiet;
    int          issue_cyc;

    function automatic logic [63:0] beat_data(input logic [31:0] a, input int k);
        logic [31:0] kk;
        kk = 32'(k);
        return {a ^ salt ^ (kk * 32'h1357_9BDF), (a + kk * 32'h0101_0101) ^ ~salt};
    endfunction

    function automatic logic [255:0] line_data(input logic [31:0] a);
        logic [255:0] l;
        l = '0;
        for (int k = 0; k < 4; k++) l[64*k +: 64] = beat_data(a, k);
        return l;
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Burst memory: one request accepted per ready cycle, beats returned in order with gaps,
    // plus occasional beats tagged with an address nobody asked for.
    initial begin
        bus_if.bmem_ready  = 1'b0;
        bus_if.bmem_rvalid = 1'b0;
        bus_if.bmem_raddr  = '0;
        bus_if.bmem_rdata  = '0;
        forever begin
            @(negedge clk);
            bus_if.bmem_rvalid = 1'b0;
            if (q_burst.size() > 0 && $urandom_range(0, 9) < 7) begin
                bus_if.bmem_rvalid = 1'b1;
                bus_if.bmem_raddr  = q_burst[0];
                bus_if.bmem_rdata  = beat_data(q_burst[0], head_beat);
                head_beat++;
                if (head_beat == 4) begin
                    head_beat     = 0;
                    last_beat_cyc = cyc;
                    void'(q_burst.pop_front());
                end
            end else if ($urandom_range(0, 4) == 0) begin
                bus_if.bmem_rvalid = 1'b1;
                bus_if.bmem_raddr  = 32'h5000_0000 | (32'($urandom_range(0, 1023)) << 5);
                bus_if.bmem_rdata  = {$urandom, $urandom};
            end
            if (ready_mode == 1)      bus_if.bmem_ready = 1'b0;
            else if (ready_mode == 2) bus_if.bmem_ready = 1'b1;
            else                      bus_if.bmem_ready = ($urandom_range(0, 3) != 0);
            if (rst === 1'b0 && bus_if.bmem_read === 1'b1 && bus_if.bmem_ready) begin
                q_burst.push_back(bus_if.bmem_addr);
                q_obs.push_back(bus_if.bmem_addr);
            end
        end
    end

    task automatic drain_obs();
        logic [31:0] o;
        while (q_obs.size() > 0) begin
            o = q_obs.pop_front();
            if (q_exp.size() == 0) chk("burst_unexpected", 256'(q_exp.size()), 256'(1));
            else                   chk("burst_addr", 256'(o), 256'(q_exp.pop_front()));
        end
    endtask

    task automatic start_read(input logic [31:0] addr, input bit quiet);
        cur_la    = {addr[31:5], 5'b0};
        cur_hit   = pf_valid && (cur_la == pf_line);
        cur_quiet = quiet;
        if (!cur_hit) q_exp.push_back(cur_la);
        q_exp.push_back(cur_la + 32'd32);
        pf_valid  = 1'b1;
        pf_line   = cur_la + 32'd32;
        bus_if.dfp_addr  = addr;
        bus_if.dfp_read  = 1'b1;
        bus_if.dfp_write = ($urandom_range(0, 3) == 0);
        issue_cyc = cyc;
    endtask

    task automatic finish_read();
        int waited;
        int exp_cyc;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus_if.dfp_resp !== 1'b1 && waited < 400);
        if (bus_if.dfp_resp !== 1'b1) begin
            chk("resp_timeout", 256'(bus_if.dfp_resp), 256'(1));
        end else begin
            chk("rdata", bus_if.dfp_rdata, line_data(cur_la));
            if (!cur_hit)      exp_cyc = last_beat_cyc + 1;
            else if (cur_quiet) exp_cyc = issue_cyc + 1;
            else               exp_cyc = last_beat_cyc + 2;
            chk(cur_hit ? "hit_latency" : "miss_latency", 256'(cyc), 256'(exp_cyc));
        end
        $display("read la=%08h hit=%0d quiet=%0d resp_cyc=%0d", cur_la, cur_hit, cur_quiet, cyc);
        bus_if.dfp_read  = 1'b0;
        bus_if.dfp_write = 1'b0;
        @(negedge clk);
        chk("resp_pulse", 256'(bus_if.dfp_resp), 256'(0));
        drain_obs();
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        @(negedge clk);
        while (n < 300 && !(q_burst.size() == 0 && bus_if.bmem_read === 1'b0
                            && bus_if.dfp_resp === 1'b0)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("quiet_timeout", 256'(n), 256'(0));
        @(negedge clk);
        drain_obs();
    endtask

    task automatic inflight_wait(input int nb);
        int n;
        n = 0;
        while (n < 300 && !(q_burst.size() > 0 && head_beat >= nb)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("inflight_timeout", 256'(n), 256'(0));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_resp"},      256'(bus_if.dfp_resp),  256'(0));
        chk({tag, "_bmem_read"}, 256'(bus_if.bmem_read), 256'(0));
        chk({tag, "_rdata"},     bus_if.dfp_rdata,       256'(0));
        chk({tag, "_bmem_addr"}, 256'(bus_if.bmem_addr), 256'(0));
    endtask

    initial begin
        logic [31:0] a;
        bit          q;
        int          n;
        salt             = $urandom;
        rst              = 1'b1;
        bus_if.dfp_addr  = '0;
        bus_if.dfp_read  = 1'b0;
        bus_if.dfp_write = 1'b0;
        bus_if.dfp_wdata = {8{$urandom}};
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Cold miss, then sequential hit once the prefetch has landed
        start_read(32'h0000_1004, 1'b1); finish_read(); wait_quiet();
        start_read(32'h0000_1020, 1'b1); finish_read();
        // Sequential request arriving while its line is still filling
        inflight_wait(2); start_read(32'h0000_1040, 1'b0); finish_read();
        // Non-sequential request during a prefetch
        inflight_wait(1); start_read(32'h0000_8000, 1'b0); finish_read(); wait_quiet();
        // Address wrap of the prefetch
        start_read(32'hFFFF_FFE7, 1'b1); finish_read(); wait_quiet();
        start_read(32'h0000_0010, 1'b1); finish_read(); wait_quiet();

        // Memory refuses requests for 10 cycles
        ready_mode = 1;
        start_read(32'h0000_3000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_bmem_read", 256'(bus_if.bmem_read), 256'(1));
            chk("stall_bmem_addr", 256'(bus_if.bmem_addr), 256'(32'h0000_3000));
        end
        ready_mode = 0;
        finish_read(); wait_quiet();

        // Reset in the middle of a demand burst; stale beats keep arriving afterwards
        start_read(32'h0000_5000, 1'b1);
        n = 0;
        while (n < 300 && !(q_burst.size() > 0 && q_burst[0] == 32'h0000_5000 && head_beat == 2)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("midburst_timeout", 256'(n), 256'(0));
        rst             = 1'b1;
        bus_if.dfp_read = 1'b0;
        @(negedge clk);
        check_idle_outputs("midburst_reset");
        drain_obs();
        q_exp.delete();
        pf_valid = 1'b0;
        rst      = 1'b0;
        // Was in the buffer before the reset; must now be fetched again
        start_read(32'h0000_3020, 1'b0); finish_read();

        for (int i = 0; i < 40; i++) begin
            q = ($urandom_range(0, 1) == 1);
            if (q) wait_quiet();
            else   inflight_wait($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) a = pf_line;
            else a = {15'b0, 12'($urandom_range(128, 2047)), 5'b0};
            start_read(a | 32'($urandom_range(0, 31)), q);
            finish_read();
        end
        wait_quiet();
        chk("burst_leftover", 256'(q_exp.size()), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
